// File: rtl/counter_pkg.sv
// Shared definitions for the T-flip-flop counter family: mode encodings and Gray conversion.
package counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Sized for the widest legal counter; callers cast down to their own width.
  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on T_i, asynchronous active-low reset to 0.
module tff_cell (
  input  logic clk_i,
  input  logic reset_i,
  input  logic T_i,
  output logic Q_o
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      Q_o <= 1'b0;
    end else if (T_i) begin
      Q_o <= ~Q_o;
    end
  end

endmodule

// File: rtl/counter_t_ff_param.sv
// Parametrised T-FF counter with up/down/Gray modes, clear, load, cascade carry and wrap pulse.
module counter_t_ff_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MOD   = 2 ** WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] Q_o,
  output logic             tc_o,
  output logic             wrap_o
);

  if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_param
    $error("counter_t_ff_param: illegal WIDTH/MOD combination");
  end

  localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] bin_q, bin_next, step_val, terminal, load_sat, toggle;
  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             over_range, wrap_step, active;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_tff (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .T_i     (toggle[i]),
      .Q_o     (bin_q[i])
    );
  end

  assign toggle     = bin_q ^ bin_next;
  assign over_range = {1'b0, bin_q} >= MOD_EXT;
  assign active     = en_i & (mode_i != MODE_HOLD) & ~clear_i & ~load_i;

  // Gray mode spans the full 2**WIDTH range, so only binary modes saturate a load.
  assign load_sat = (({1'b0, load_val_i} >= MOD_EXT) && (mode_i != MODE_GRAY)) ?
                    TOP_VAL : load_val_i;

  always_comb begin
    terminal  = TOP_VAL;
    wrap_step = 1'b0;
    step_val  = bin_q;
    case (mode_i)
      MODE_UP: begin
        terminal  = TOP_VAL;
        wrap_step = (bin_q == TOP_VAL) || over_range;
        step_val  = wrap_step ? '0 : bin_q + ONE;
      end
      MODE_DOWN: begin
        terminal  = '0;
        wrap_step = (bin_q == '0) || over_range;
        step_val  = wrap_step ? TOP_VAL : bin_q - ONE;
      end
      MODE_GRAY: begin
        terminal  = ALL_ONES;
        wrap_step = (bin_q == ALL_ONES);
        step_val  = bin_q + ONE;
      end
      default: begin
        terminal  = TOP_VAL;
        wrap_step = 1'b0;
        step_val  = bin_q;
      end
    endcase
  end

  always_comb begin
    bin_next = bin_q;
    if (clear_i) begin
      bin_next = '0;
    end else if (load_i) begin
      bin_next = load_sat;
    end else if (active) begin
      bin_next = step_val;
    end
  end

  always_comb begin
    q_d = bin_next;
    case (mode_i)
      MODE_GRAY: q_d = WIDTH'(bin2gray(16'(bin_next)));
      MODE_HOLD: q_d = q_q;
      default:   q_d = bin_next;
    endcase
  end

  assign wrap_d = active & wrap_step;
  assign tc_o   = active & (bin_q == terminal);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q_o    = q_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_counter_t_ff_param.sv
// Directed bench for counter_t_ff_param (WIDTH=3, MOD=6) plus a two-stage cascade.
module tb_counter_t_ff_param;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       en, clear, load;
  logic [1:0] mode;
  logic [2:0] load_val;
  logic [2:0] q;
  logic       tc, wrap;

  logic       en_c;
  logic [2:0] q0, q1;
  logic       tc0, tc1, wrap0, wrap1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_t_ff_param #(.WIDTH(3), .MOD(6)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en),
    .mode_i     (mode),
    .clear_i    (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .Q_o        (q),
    .tc_o       (tc),
    .wrap_o     (wrap)
  );

  counter_t_ff_param #(.WIDTH(3), .MOD(6)) stage0 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_c),
    .mode_i     (2'b00),
    .clear_i    (1'b0),
    .load_i     (1'b0),
    .load_val_i (3'd0),
    .Q_o        (q0),
    .tc_o       (tc0),
    .wrap_o     (wrap0)
  );

  counter_t_ff_param #(.WIDTH(3), .MOD(6)) stage1 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (tc0),
    .mode_i     (2'b00),
    .clear_i    (1'b0),
    .load_i     (1'b0),
    .load_val_i (3'd0),
    .Q_o        (q1),
    .tc_o       (tc1),
    .wrap_o     (wrap1)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (q !== 3'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%0b want=0", tc); end
    total++; if (q0 !== 3'd0 || q1 !== 3'd0) begin
      bad++; $display("FAIL reset_cascade got=%0d,%0d want=0,0", q1, q0);
    end
    en = 1'b1; mode = 2'b01; #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down got=%0b want=1", tc); end
    mode = 2'b00; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc_up got=%0b want=0", tc); end
  endtask

  task automatic test_up();
    logic [2:0] exp_q [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    @(negedge clk);
    reset_i = 1'b1; en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (tc !== (i == 5)) begin
        bad++; $display("FAIL up_tc[%0d] got=%0b want=%0b", i, tc, (i == 5));
      end
      @(posedge clk); #1;
      total++; if (q !== exp_q[i]) begin
        bad++; $display("FAIL up_q[%0d] got=%0d want=%0d", i, q, exp_q[i]);
      end
      total++; if (wrap !== (i == 5)) begin
        bad++; $display("FAIL up_wrap[%0d] got=%0b want=%0b", i, wrap, (i == 5));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_down();
    logic [2:0] exp_q [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    en = 1'b0; load = 1'b1; load_val = 3'd7; mode = 2'b00;
    @(posedge clk); #1;
    total++; if (q !== 3'd5) begin bad++; $display("FAIL load_sat got=%0d want=5", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load_wrap got=%0b want=0", wrap); end
    @(negedge clk);
    load = 1'b0; mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (tc !== (i == 5)) begin
        bad++; $display("FAIL down_tc[%0d] got=%0b want=%0b", i, tc, (i == 5));
      end
      @(posedge clk); #1;
      total++; if (q !== exp_q[i]) begin
        bad++; $display("FAIL down_q[%0d] got=%0d want=%0d", i, q, exp_q[i]);
      end
      total++; if (wrap !== (i == 5)) begin
        bad++; $display("FAIL down_wrap[%0d] got=%0b want=%0b", i, wrap, (i == 5));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gray();
    logic [2:0] exp_q [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    clear = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    total++; if (q !== 3'd0) begin bad++; $display("FAIL clear_q got=%0d want=0", q); end
    @(negedge clk);
    clear = 1'b0; mode = 2'b10; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (tc !== (i == 7)) begin
        bad++; $display("FAIL gray_tc[%0d] got=%0b want=%0b", i, tc, (i == 7));
      end
      @(posedge clk); #1;
      total++; if (q !== exp_q[i]) begin
        bad++; $display("FAIL gray_q[%0d] got=%b want=%b", i, q, exp_q[i]);
      end
      total++; if (wrap !== (i == 7)) begin
        bad++; $display("FAIL gray_wrap[%0d] got=%0b want=%0b", i, wrap, (i == 7));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_and_mode_change();
    logic [1:0] modes [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00};
    logic       ens   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_q [6] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
    for (int i = 0; i < 6; i++) begin
      mode = modes[i]; en = ens[i];
      @(posedge clk); #1;
      total++; if (q !== exp_q[i]) begin
        bad++; $display("FAIL hold_q[%0d] got=%0d want=%0d", i, q, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_priority();
    clear = 1'b1; load = 1'b1; load_val = 3'd3; en = 1'b1; mode = 2'b00;
    @(posedge clk); #1;
    total++; if (q !== 3'd0) begin bad++; $display("FAIL prio_clear got=%0d want=0", q); end
    @(negedge clk);
    clear = 1'b0;
    @(posedge clk); #1;
    total++; if (q !== 3'd3) begin bad++; $display("FAIL prio_load got=%0d want=3", q); end
    @(negedge clk);
    load_val = 3'd5; en = 1'b0;
    @(posedge clk); #1;
    total++; if (q !== 3'd5) begin bad++; $display("FAIL load5 got=%0d want=5", q); end
    @(negedge clk);
    load = 1'b0; clear = 1'b1; en = 1'b1; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL tc_masked got=%0b want=0", tc); end
    @(posedge clk); #1;
    total++; if (q !== 3'd0 || wrap !== 1'b0) begin
      bad++; $display("FAIL clear_at_tc got=%0d/%0b want=0/0", q, wrap);
    end
    @(negedge clk);
    clear = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = 2'b00; en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (q !== 3'd4) begin bad++; $display("FAIL mid_pre got=%0d want=4", q); end
    reset_i = 1'b0; #1;
    total++; if (q !== 3'd0) begin bad++; $display("FAIL mid_async_q got=%0d want=0", q); end
    #1 reset_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (q !== 3'd0 || wrap !== 1'b1) begin
      bad++; $display("FAIL mid_wrap_pre got=%0d/%0b want=0/1", q, wrap);
    end
    reset_i = 1'b0; #1;
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL mid_wrap_drop got=%0b want=0", wrap); end
    #1 reset_i = 1'b1; en = 1'b0;
  endtask

  task automatic test_cascade();
    int comb;
    @(negedge clk);
    en_c = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      comb = int'(q1) * 6 + int'(q0);
      total++; if (comb !== (k % 36)) begin
        bad++; $display("FAIL cascade[%0d] got=%0d want=%0d", k, comb, k % 36);
      end
      if (k == 35) begin
        total++; if (tc1 !== 1'b1) begin bad++; $display("FAIL cascade_tc1 got=%0b want=1", tc1); end
      end
    end
    total++; if (wrap1 !== 1'b1) begin bad++; $display("FAIL cascade_wrap1 got=%0b want=1", wrap1); end
    en_c = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; en = 1'b0; mode = 2'b00; clear = 1'b0; load = 1'b0;
    load_val = 3'd0; en_c = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_gray();
    test_hold_and_mode_change();
    test_priority();
    test_reset_mid();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
